// File: rtl/fgen_sequencer.sv
// Function-generator block sequencer.
// Walks address 0..3 for PASSES sweeps per block. It pulses acc_clr before the
// first word and pulses done after the last accepted word. It also keeps a
// wrapping count of completed blocks. Every output comes straight from a flop.
module fgen_sequencer #(
    parameter int PASSES = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dp_ready,
    output logic [1:0]       adrs,
    output logic             fg_rst,
    output logic             f_valid,
    output logic             acc_clr,
    output logic [7:0]       pass_idx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {IDLE, CLR, ISSUE, DONE} state_t;

    localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

    state_t           state_q, state_d;
    logic [1:0]       adrs_q, adrs_d;
    logic [7:0]       pass_q, pass_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic             fg_rst_q, fg_rst_d;
    logic             f_valid_q, f_valid_d;
    logic             acc_clr_q, acc_clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next state, counters, and output values. The output values are decoded
    // from the next state, so each output flop holds the value for the state
    // being entered.
    always_comb begin
        state_d = state_q;
        adrs_d  = adrs_q;
        pass_d  = pass_q;
        blk_d   = blk_q;

        case (state_q)
            IDLE: begin
                adrs_d = 2'd0;
                pass_d = 8'd0;
                if (start) state_d = CLR;
            end
            CLR: begin
                adrs_d  = 2'd0;
                pass_d  = 8'd0;
                state_d = abort ? IDLE : ISSUE;
            end
            ISSUE: begin
                if (abort) begin
                    // Abort beats a coincident final acceptance.
                    state_d = IDLE;
                    adrs_d  = 2'd0;
                    pass_d  = 8'd0;
                end else if (dp_ready) begin
                    if (adrs_q != 2'd3) begin
                        adrs_d = adrs_q + 2'd1;
                    end else if (pass_q != LAST_PASS) begin
                        adrs_d = 2'd0;
                        pass_d = pass_q + 8'd1;
                    end else begin
                        // Count the block on entry to DONE, so blk_cnt already
                        // shows the new value while done is high.
                        state_d = DONE;
                        adrs_d  = 2'd0;
                        blk_d   = blk_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                adrs_d  = 2'd0;
                pass_d  = 8'd0;
            end
            default: state_d = IDLE;
        endcase

        fg_rst_d  = (state_d == IDLE) || (state_d == DONE);
        f_valid_d = (state_d == ISSUE);
        acc_clr_d = (state_d == CLR);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State, counters, and output flops; rst forces idle values at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            adrs_q    <= 2'd0;
            pass_q    <= 8'd0;
            blk_q     <= '0;
            fg_rst_q  <= 1'b1;
            f_valid_q <= 1'b0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            adrs_q    <= adrs_d;
            pass_q    <= pass_d;
            blk_q     <= blk_d;
            fg_rst_q  <= fg_rst_d;
            f_valid_q <= f_valid_d;
            acc_clr_q <= acc_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign adrs     = adrs_q;
    assign pass_idx = pass_q;
    assign blk_cnt  = blk_q;
    assign fg_rst   = fg_rst_q;
    assign f_valid  = f_valid_q;
    assign acc_clr  = acc_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
